sram_arb: RTL and testbench

Arbitrated controller for the board's 8-bit asynchronous external SRAM. It replaces bit-banging the SRAM control pins from GPIO. Two requesters share the part:
- a video read port, high priority, used by the scan-out engine;
- a CPU read/write port, which the I/O decoder drives on the j1 memory-mapped bus.

Address/data widths and access wait-states are parameters. Bounded video bursts guarantee the CPU port forward progress.

---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_arb.sv | 174 +++++++++++++++++
 tb/tb_sram_arb.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared constants and state encoding for the external SRAM controller and its clients.
package sram_pkg;

    localparam int unsigned SramAw = 21;
    localparam int unsigned SramDw = 8;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRead    = 3'd1,
        StWrSetup = 3'd2,
        StWrPulse = 3'd3,
        StWrHold  = 3'd4
    } state_e;

endpackage

// File: rtl/sram_arb.sv
// Two-port arbitrated controller for an asynchronous external SRAM: prioritised video reads,
// CPU reads/writes, with bounded video bursts so a waiting CPU always gets through.
module sram_arb
    import sram_pkg::*;
#(
    parameter int unsigned AW        = SramAw,
    parameter int unsigned DW        = SramDw,
    parameter int unsigned RD_CYCLES = 2,
    parameter int unsigned WR_CYCLES = 2,
    parameter int unsigned VBURST    = 4
) (
    input  logic          clk,
    input  logic          resetq,

    input  logic          v_req,
    input  logic [AW-1:0] v_addr,
    output logic          v_ack,
    output logic [DW-1:0] v_data,

    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic [DW-1:0] c_rdata,

    output logic          busy,

    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_dq_o,
    output logic          sram_dq_oe,
    input  logic [DW-1:0] sram_dq_i,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n
);

    localparam int unsigned CntMax = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int unsigned VcW    = $clog2(VBURST + 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [VcW-1:0]  vcount_q, vcount_d;
    logic            own_cpu_q, own_cpu_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   v_data_q, v_data_d;
    logic [DW-1:0]   c_rdata_q, c_rdata_d;
    logic            v_ack_q, v_ack_d;
    logic            c_ack_q, c_ack_d;

    logic v_win, c_win, grant_v, grant_c;

    // Priority is decided on raw requests; the winner is then blocked if it was just acked,
    // which leaves a mask cycle instead of handing the slot to the loser.
    always_comb begin
        v_win   = v_req && !(c_req && (vcount_q == VcW'(VBURST)));
        c_win   = c_req && !v_win;
        grant_v = (state_q == StIdle) && v_win && !v_ack_q;
        grant_c = (state_q == StIdle) && c_win && !c_ack_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vcount_d  = vcount_q;
        own_cpu_d = own_cpu_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        v_data_d  = v_data_q;
        c_rdata_d = c_rdata_q;
        v_ack_d   = 1'b0;
        c_ack_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_v) begin
                    addr_d    = v_addr;
                    own_cpu_d = 1'b0;
                    cnt_d     = CntW'(RD_CYCLES - 1);
                    state_d   = StRead;
                    if (c_req && (vcount_q != VcW'(VBURST))) begin
                        vcount_d = vcount_q + 1'b1;
                    end
                end else if (grant_c) begin
                    addr_d    = c_addr;
                    wdata_d   = c_wdata;
                    own_cpu_d = 1'b1;
                    vcount_d  = '0;
                    cnt_d     = CntW'(RD_CYCLES - 1);
                    state_d   = c_we ? StWrSetup : StRead;
                end
            end
            StRead: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    if (own_cpu_q) begin
                        c_rdata_d = sram_dq_i;
                        c_ack_d   = 1'b1;
                    end else begin
                        v_data_d = sram_dq_i;
                        v_ack_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrSetup: begin
                cnt_d   = CntW'(WR_CYCLES - 1);
                state_d = StWrPulse;
            end
            StWrPulse: begin
                if (cnt_q == '0) begin
                    state_d = StWrHold;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrHold: begin
                c_ack_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (!c_req) begin
            vcount_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            vcount_q  <= '0;
            own_cpu_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            v_data_q  <= '0;
            c_rdata_q <= '0;
            v_ack_q   <= 1'b0;
            c_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vcount_q  <= vcount_d;
            own_cpu_q <= own_cpu_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            v_data_q  <= v_data_d;
            c_rdata_q <= c_rdata_d;
            v_ack_q   <= v_ack_d;
            c_ack_q   <= c_ack_d;
        end
    end

    // Strobes decode straight from the state register, so dq_oe and oe_n can never overlap.
    always_comb begin
        sram_ce_n  = (state_q == StIdle);
        sram_oe_n  = (state_q != StRead);
        sram_we_n  = (state_q != StWrPulse);
        sram_dq_oe = (state_q == StWrSetup) || (state_q == StWrPulse) || (state_q == StWrHold);
        busy       = (state_q != StIdle);
    end

    assign sram_addr = addr_q;
    assign sram_dq_o = wdata_q;
    assign v_ack     = v_ack_q;
    assign v_data    = v_data_q;
    assign c_ack     = c_ack_q;
    assign c_rdata   = c_rdata_q;

endmodule

// File: tb/tb_sram_arb.sv
// Bench for sram_arb: two instances (default timing and RD=4/WR=1) against a simple SRAM
// model, with a scoreboard of expected acks checked as they appear.
module tb_sram_arb;

    typedef struct {
        bit         is_c;
        bit         we;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic        v_req [2];
    logic [20:0] v_addr [2];
    logic        v_ack [2];
    logic [7:0]  v_data [2];
    logic        c_req [2];
    logic        c_we [2];
    logic [20:0] c_addr [2];
    logic [7:0]  c_wdata [2];
    logic        c_ack [2];
    logic [7:0]  c_rdata [2];
    logic        busy [2];
    logic [20:0] sram_addr [2];
    logic [7:0]  sram_dq_o [2];
    logic        sram_dq_oe [2];
    logic [7:0]  sram_dq_i [2];
    logic        sram_ce_n [2];
    logic        sram_oe_n [2];
    logic        sram_we_n [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int act = 0;
    int v_acks = 0;
    int c_acks = 0;
    exp_t sbq[$];

    bit prev_v, prev_c;
    bit we_any, oe_any, dq_any;
    int we_first, we_last, oe_first, oe_last, dq_first, dq_last;
    bit quiet_after_we = 1'b1;
    bit gap_at_oe;
    bit prev_oe_n = 1'b1;

    function automatic logic [7:0] exp_mem(input int a);
        return 8'(a * 7 + 3);
    endfunction

    function automatic int rd_of(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic int wr_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0] mem [0:1023];

        sram_arb #(
            .AW(21), .DW(8),
            .RD_CYCLES((g == 0) ? 2 : 4),
            .WR_CYCLES((g == 0) ? 2 : 1),
            .VBURST(4)
        ) u_dut (
            .clk(clk), .resetq(resetq),
            .v_req(v_req[g]), .v_addr(v_addr[g]), .v_ack(v_ack[g]), .v_data(v_data[g]),
            .c_req(c_req[g]), .c_we(c_we[g]), .c_addr(c_addr[g]), .c_wdata(c_wdata[g]),
            .c_ack(c_ack[g]), .c_rdata(c_rdata[g]), .busy(busy[g]),
            .sram_addr(sram_addr[g]), .sram_dq_o(sram_dq_o[g]), .sram_dq_oe(sram_dq_oe[g]),
            .sram_dq_i(sram_dq_i[g]), .sram_ce_n(sram_ce_n[g]), .sram_oe_n(sram_oe_n[g]),
            .sram_we_n(sram_we_n[g])
        );

        initial for (int i = 0; i < 1024; i++) mem[i] = exp_mem(i);

        always @(posedge clk)
            if (!sram_ce_n[g] && !sram_we_n[g]) mem[sram_addr[g][9:0]] <= sram_dq_o[g];

        assign sram_dq_i[g] = (!sram_ce_n[g] && !sram_oe_n[g]) ? mem[sram_addr[g][9:0]] : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic sb_pop(input bit is_c);
        exp_t e;
        logic [7:0] got;
        if (sbq.size() == 0) begin
            check(is_c ? "unexpected_c_ack" : "unexpected_v_ack", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            check("ack_port", 32'(is_c), 32'(e.is_c));
            if (is_c && e.we) got = sram_dq_o[act];
            else              got = is_c ? c_rdata[act] : v_data[act];
            check(e.we ? "write_data" : "read_data", 32'(got), 32'(e.data));
            if (e.cyc >= 0) check("ack_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        check("oe_dq_excl", 32'(sram_dq_oe[act] & ~sram_oe_n[act]), 32'd0);
        if (v_ack[act]) begin
            check("v_ack_width", 32'(prev_v), 32'd0);
            v_acks++;
            sb_pop(1'b0);
        end
        if (c_ack[act]) begin
            check("c_ack_width", 32'(prev_c), 32'd0);
            c_acks++;
            sb_pop(1'b1);
        end
        prev_v = v_ack[act];
        prev_c = c_ack[act];
        if (!sram_we_n[act]) begin
            if (!we_any) we_first = cyc;
            we_last = cyc; we_any = 1'b1;
        end
        if (!sram_oe_n[act]) begin
            if (!oe_any) oe_first = cyc;
            oe_last = cyc; oe_any = 1'b1;
        end
        if (sram_dq_oe[act]) begin
            if (!dq_any) dq_first = cyc;
            dq_last = cyc; dq_any = 1'b1;
        end
        // Was there a fully quiet bus cycle between the last write pulse and this read?
        if (!sram_we_n[act]) quiet_after_we = 1'b0;
        else if (sram_ce_n[act] && sram_oe_n[act] && !sram_dq_oe[act]) quiet_after_we = 1'b1;
        if (!sram_oe_n[act] && prev_oe_n) gap_at_oe = quiet_after_we;
        prev_oe_n = sram_oe_n[act];
    end

    task automatic clear_trk();
        we_any = 1'b0; oe_any = 1'b0; dq_any = 1'b0;
    endtask

    task automatic push_exp(input bit is_c, input bit we, input logic [7:0] d, input int c);
        exp_t e;
        e.is_c = is_c; e.we = we; e.data = d; e.cyc = c;
        sbq.push_back(e);
    endtask

    task automatic wait_ack(input bit is_c, output bit ok);
        int n0;
        n0 = is_c ? c_acks : v_acks;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk); #1;
            if ((is_c ? c_acks : v_acks) != n0) ok = 1'b1;
        end
        if (!ok) check(is_c ? "c_ack_timeout" : "v_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic cpu_op(input int inst, input bit we, input logic [20:0] a,
                          input logic [7:0] d, input logic [7:0] rexp);
        int t;
        bit ok;
        @(posedge clk); #1;
        clear_trk();
        c_we[inst] = we; c_addr[inst] = a; c_wdata[inst] = d; c_req[inst] = 1'b1;
        t = cyc;
        push_exp(1'b1, we, we ? d : rexp, we ? t + wr_of(inst) + 3 : t + rd_of(inst) + 1);
        wait_ack(1'b1, ok);
        if (ok && we) begin
            check("we_first", 32'(we_first), 32'(t + 2));
            check("we_last", 32'(we_last), 32'(t + 1 + wr_of(inst)));
            check("dq_oe_first", 32'(dq_first), 32'(t + 1));
            check("dq_oe_last", 32'(dq_last), 32'(t + 2 + wr_of(inst)));
            check("wr_no_oe", 32'(oe_any), 32'd0);
        end else if (ok) begin
            check("oe_first", 32'(oe_first), 32'(t + 1));
            check("oe_last", 32'(oe_last), 32'(t + rd_of(inst)));
            check("rd_no_dq_oe", 32'(dq_any), 32'd0);
            check("rd_no_we", 32'(we_any), 32'd0);
        end
        @(posedge clk); #1;
        c_req[inst] = 1'b0;
    endtask

    task automatic v_op(input int inst, input logic [20:0] a);
        int t;
        bit ok;
        @(posedge clk); #1;
        clear_trk();
        v_addr[inst] = a; v_req[inst] = 1'b1;
        t = cyc;
        push_exp(1'b0, 1'b0, exp_mem(int'(a)), t + rd_of(inst) + 1);
        wait_ack(1'b0, ok);
        if (ok) begin
            check("v_oe_first", 32'(oe_first), 32'(t + 1));
            check("v_oe_last", 32'(oe_last), 32'(t + rd_of(inst)));
        end
        @(posedge clk); #1;
        v_req[inst] = 1'b0;
    endtask

    task automatic v_agent(input int inst, input int n);
        bit ok;
        @(posedge clk); #1;
        v_addr[inst] = 21'h100; v_req[inst] = 1'b1;
        for (int k = 0; k < n; k++) begin
            wait_ack(1'b0, ok);
            if (!ok) break;
            @(posedge clk); #1;
            v_addr[inst] = 21'h101 + 21'(k);
        end
        v_req[inst] = 1'b0;
    endtask

    task automatic c_agent(input int inst, input int n);
        bit ok;
        @(posedge clk); #1;
        c_we[inst] = 1'b0; c_addr[inst] = 21'h200; c_req[inst] = 1'b1;
        for (int k = 0; k < n; k++) begin
            wait_ack(1'b1, ok);
            if (!ok) break;
            @(posedge clk); #1;
            c_addr[inst] = 21'h201 + 21'(k);
        end
        c_req[inst] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t;
        bit ok;
        for (int i = 0; i < 2; i++) begin
            v_req[i] = 1'b0; v_addr[i] = '0; c_req[i] = 1'b0; c_we[i] = 1'b0;
            c_addr[i] = '0; c_wdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_strobes", 32'({sram_ce_n[i], sram_oe_n[i], sram_we_n[i]}), 32'h7);
            check("rst_dq_oe", 32'(sram_dq_oe[i]), 32'd0);
            check("rst_acks_busy", 32'({v_ack[i], c_ack[i], busy[i]}), 32'd0);
            check("rst_addr", 32'(sram_addr[i]), 32'd0);
            check("rst_data", 32'({sram_dq_o[i], v_data[i], c_rdata[i]}), 32'd0);
        end
        @(posedge clk); #1;
        resetq = 1'b1;

        cpu_op(0, 1'b1, 21'h00123, 8'h5A, 8'h00);
        cpu_op(0, 1'b0, 21'h00123, 8'h00, 8'h5A);
        v_op(0, 21'h300);

        // Reset in the middle of a write pulse must drop WE on the same edge and lose the ack.
        @(posedge clk); #1;
        c_we[0] = 1'b1; c_addr[0] = 21'h55; c_wdata[0] = 8'hA5; c_req[0] = 1'b1;
        t = cyc;
        repeat (2) @(posedge clk);
        #1;
        check("mid_in_pulse", 32'(sram_we_n[0]), 32'd0);
        resetq = 1'b0; c_req[0] = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_we_n", 32'(sram_we_n[0]), 32'd1);
        check("mid_rst_c_ack", 32'(c_ack[0]), 32'd0);
        check("mid_rst_busy", 32'(busy[0]), 32'd0);
        check("mid_rst_addr", 32'(sram_addr[0]), 32'd0);
        @(posedge clk); #1;
        resetq = 1'b1;
        repeat (6) @(posedge clk);
        cpu_op(0, 1'b0, 21'h00123, 8'h00, 8'h5A);

        // Both ports held: four video grants, then the CPU, twice over.
        for (int k = 0; k < 4; k++) push_exp(1'b0, 1'b0, exp_mem(16'h100 + k), -1);
        push_exp(1'b1, 1'b0, exp_mem(16'h200), -1);
        for (int k = 4; k < 8; k++) push_exp(1'b0, 1'b0, exp_mem(16'h100 + k), -1);
        push_exp(1'b1, 1'b0, exp_mem(16'h201), -1);
        fork
            v_agent(0, 8);
            c_agent(0, 2);
        join
        check("burst_sb_drained", 32'(sbq.size()), 32'd0);

        // Write with a video read queued behind it: bus must go quiet before OE falls.
        gap_at_oe = 1'b0;
        fork
            cpu_op(0, 1'b1, 21'h010, 8'h3C, 8'h00);
            begin
                @(posedge clk); @(posedge clk); #1;
                v_addr[0] = 21'h020; v_req[0] = 1'b1;
                push_exp(1'b0, 1'b0, exp_mem(16'h020), cyc + 7);
                wait_ack(1'b0, ok);
                @(posedge clk); #1;
                v_req[0] = 1'b0;
            end
        join
        check("turnaround_gap", 32'(gap_at_oe), 32'd1);
        check("c_rdata_held", 32'(c_rdata[0]), 32'(exp_mem(16'h201)));

        repeat (3) @(posedge clk);
        act = 1;
        cpu_op(1, 1'b1, 21'h040, 8'h77, 8'h00);
        cpu_op(1, 1'b0, 21'h040, 8'h00, 8'h77);
        v_op(1, 21'h301);

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
